dcache_ctrl: RTL and testbench

- Direct-mapped, write-back data cache. Sits between the cpu data-memory port and the main data memory.
- Acts as responder to the cpu READ/WRITE/ADDRESS/WRITEDATA/READDATA/BUSYWAIT handshake.
- Acts as initiator of 4-byte block transfers to main memory over a mem_* busywait handshake.
- Hits complete in the request cycle. Misses stall the cpu via BUSYWAIT until the block is refilled, with writeback first if the victim is dirty.

---
 rtl/dcache_ctrl.sv | 115 +++++++++++
 tb/tb_dcache_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back data cache between the cpu data port and block memory.
// Hits complete combinationally. Misses stall the cpu while a dirty victim is written back and the block is refilled.
module dcache_ctrl #(
  parameter int INDEX_BITS = 3,
  parameter int TAG_BITS   = 8 - 2 - INDEX_BITS
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic                         READ,
  input  logic                         WRITE,
  input  logic [7:0]                   ADDRESS,
  input  logic [7:0]                   WRITEDATA,
  output logic [7:0]                   READDATA,
  output logic                         BUSYWAIT,
  output logic                         mem_read,
  output logic                         mem_write,
  output logic [TAG_BITS+INDEX_BITS-1:0] mem_address,
  output logic [31:0]                  mem_writedata,
  input  logic [31:0]                  mem_readdata,
  input  logic                         mem_busywait
);
  localparam int NUM_SETS = 2 ** INDEX_BITS;

  typedef enum logic [1:0] {IDLE, WB, FILL, UPDATE} state_t;

  state_t                 state_q, state_d;
  logic [NUM_SETS-1:0]    valid_q, dirty_q;
  logic [TAG_BITS-1:0]    tag_q  [NUM_SETS];
  logic [31:0]            data_q [NUM_SETS];
  logic [TAG_BITS-1:0]    miss_tag_q;
  logic [INDEX_BITS-1:0]  miss_idx_q;

  logic [TAG_BITS-1:0]    addr_tag;
  logic [INDEX_BITS-1:0]  addr_idx;
  logic [1:0]             addr_off;
  logic                   req, hit, wr_hit, miss_start, fill_done;

  assign addr_tag   = ADDRESS[7 -: TAG_BITS];
  assign addr_idx   = ADDRESS[INDEX_BITS+1:2];
  assign addr_off   = ADDRESS[1:0];
  assign req        = READ | WRITE;
  assign hit        = valid_q[addr_idx] && (tag_q[addr_idx] == addr_tag);
  assign wr_hit     = (state_q == IDLE) && WRITE && hit;
  assign miss_start = (state_q == IDLE) && req && !hit;
  assign fill_done  = (state_q == FILL) && !mem_busywait;

  always_comb begin
    state_d       = state_q;
    BUSYWAIT      = 1'b0;
    READDATA      = 8'h00;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_address   = '0;
    mem_writedata = 32'h0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (hit) begin
            // A simultaneous READ/WRITE is a store, so no load data is returned.
            if (!WRITE) READDATA = data_q[addr_idx][{addr_off, 3'b000} +: 8];
          end else begin
            BUSYWAIT = 1'b1;
            state_d  = (valid_q[addr_idx] && dirty_q[addr_idx]) ? WB : FILL;
          end
        end
      end
      WB: begin
        BUSYWAIT      = 1'b1;
        mem_write     = 1'b1;
        mem_address   = {tag_q[miss_idx_q], miss_idx_q};
        mem_writedata = data_q[miss_idx_q];
        if (!mem_busywait) state_d = FILL;
      end
      FILL: begin
        BUSYWAIT    = 1'b1;
        mem_read    = 1'b1;
        mem_address = {miss_tag_q, miss_idx_q};
        if (!mem_busywait) state_d = UPDATE;
      end
      UPDATE: begin
        BUSYWAIT = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      if (fill_done) begin
        valid_q[miss_idx_q] <= 1'b1;
        dirty_q[miss_idx_q] <= 1'b0;
      end
      if (wr_hit) dirty_q[addr_idx] <= 1'b1;
    end
  end

  // The miss address is latched so a cpu that drops its request mid-miss cannot redirect the transfer.
  always_ff @(posedge CLK) begin
    if (miss_start) begin
      miss_tag_q <= addr_tag;
      miss_idx_q <= addr_idx;
    end
    if (fill_done) begin
      tag_q[miss_idx_q]  <= miss_tag_q;
      data_q[miss_idx_q] <= mem_readdata;
    end
    if (wr_hit) data_q[addr_idx][{addr_off, 3'b000} +: 8] <= WRITEDATA;
  end
endmodule

// File: tb/tb_dcache_ctrl.sv
// Randomized bench for dcache_ctrl: a behavioural cache/memory model predicts hits, stall length,
// writeback traffic and load data for every cpu access.
module tb_dcache_ctrl;
  logic        CLK = 1'b0;
  logic        RESET, READ, WRITE;
  logic [7:0]  ADDRESS, WRITEDATA, READDATA;
  logic        BUSYWAIT, mem_read, mem_write, mem_busywait;
  logic [5:0]  mem_address;
  logic [31:0] mem_writedata, mem_readdata;

  dcache_ctrl dut (
    .CLK(CLK), .RESET(RESET), .READ(READ), .WRITE(WRITE), .ADDRESS(ADDRESS),
    .WRITEDATA(WRITEDATA), .READDATA(READDATA), .BUSYWAIT(BUSYWAIT),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata), .mem_busywait(mem_busywait)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Main memory: answers each transfer after mem_lat cycles (busywait high mem_lat-1 cycles).
  logic [31:0] mem_arr [64];
  int          mem_lat = 1;
  int          mem_cnt = 0;
  logic [1:0]  prev_kind = 2'b00;
  logic [1:0]  kind;

  initial begin
    mem_busywait = 1'b0;
    mem_readdata = 32'h0;
  end

  always @(negedge CLK) begin
    kind = {mem_read, mem_write};
    if (kind != prev_kind) mem_cnt = 0;
    if (kind == 2'b10 || kind == 2'b01) begin
      mem_busywait = (mem_cnt < mem_lat - 1);
      mem_cnt++;
      if (mem_read) mem_readdata = mem_arr[mem_address];
      if (mem_write && !mem_busywait) mem_arr[mem_address] = mem_writedata;
    end else begin
      mem_busywait = 1'b0;
    end
    prev_kind = kind;
  end

  // Reference cache contents.
  bit          m_valid [8];
  bit          m_dirty [8];
  logic [2:0]  m_tag   [8];
  logic [31:0] m_data  [8];

  int          obs_busy, obs_rd_cyc, obs_wr_cyc;
  bit          obs_saw_wr, obs_saw_rd;
  logic [5:0]  obs_wb_addr, obs_rd_addr;
  logic [31:0] obs_wb_data;
  logic [7:0]  obs_rdata;
  int          txn = 0;

  task automatic access(input bit wr, input logic [7:0] a, input logic [7:0] wd, input int lat);
    logic [2:0]  idx, tg;
    logic [1:0]  off;
    bit          exp_hit, exp_wb, done;
    logic [5:0]  exp_wb_addr;
    logic [31:0] exp_wb_data;
    logic [7:0]  exp_rd;
    int          exp_busy, both;
    idx = a[4:2]; tg = a[7:5]; off = a[1:0];
    exp_hit     = m_valid[idx] && (m_tag[idx] == tg);
    exp_wb      = !exp_hit && m_valid[idx] && m_dirty[idx];
    exp_wb_addr = {m_tag[idx], idx};
    exp_wb_data = m_data[idx];
    exp_busy    = exp_hit ? 0 : (exp_wb ? 2 * lat + 2 : lat + 2);

    mem_lat = lat;
    @(negedge CLK);
    READ = !wr; WRITE = wr; ADDRESS = a; WRITEDATA = wd;
    obs_busy = 0; obs_rd_cyc = 0; obs_wr_cyc = 0; both = 0;
    obs_saw_wr = 0; obs_saw_rd = 0; done = 0;
    obs_wb_addr = '0; obs_wb_data = '0; obs_rd_addr = '0;
    for (int c = 0; c < 300 && !done; c++) begin
      #1;
      if (!BUSYWAIT) begin
        done = 1;
      end else begin
        obs_busy++;
        if (mem_write) begin
          if (!obs_saw_wr) begin obs_wb_addr = mem_address; obs_wb_data = mem_writedata; end
          obs_saw_wr = 1; obs_wr_cyc++;
        end
        if (mem_read) begin obs_rd_addr = mem_address; obs_saw_rd = 1; obs_rd_cyc++; end
        if (mem_read && mem_write) both++;
        @(negedge CLK);
      end
    end
    check("timeout", {31'b0, done}, 32'd1);
    obs_rdata = READDATA;

    if (!exp_hit) begin
      m_valid[idx] = 1; m_dirty[idx] = 0; m_tag[idx] = tg;
      m_data[idx]  = mem_arr[{tg, idx}];
    end
    if (wr) begin
      m_data[idx][off*8 +: 8] = wd;
      m_dirty[idx] = 1;
    end
    exp_rd = wr ? 8'h00 : m_data[idx][off*8 +: 8];

    check("busy_cycles", obs_busy, exp_busy);
    check("readdata", {24'b0, obs_rdata}, {24'b0, exp_rd});
    check("wb_seen", {31'b0, obs_saw_wr}, {31'b0, exp_wb});
    check("fill_seen", {31'b0, obs_saw_rd}, {31'b0, !exp_hit});
    check("rd_wr_both", both, 0);
    if (exp_wb) begin
      check("wb_addr", {26'b0, obs_wb_addr}, {26'b0, exp_wb_addr});
      check("wb_data", obs_wb_data, exp_wb_data);
      check("wb_cycles", obs_wr_cyc, lat);
    end
    if (!exp_hit) begin
      check("fill_addr", {26'b0, obs_rd_addr}, {26'b0, tg, idx});
      check("fill_cycles", obs_rd_cyc, lat);
    end
    @(posedge CLK); #1;
    READ = 0; WRITE = 0;
    $display("txn %0d %s addr=%h wd=%h lat=%0d busy=%0d wb=%0d rd=%h", txn, wr ? "WR" : "RD",
             a, wd, lat, obs_busy, obs_saw_wr, obs_rdata);
    txn++;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin m_valid[i] = 0; m_dirty[i] = 0; end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem_arr[i] = $urandom;
    mem_arr[6'h09] = 32'hDDCCBBAA;
    model_reset();
    RESET = 1; READ = 0; WRITE = 0; ADDRESS = 0; WRITEDATA = 0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_busywait", {31'b0, BUSYWAIT}, 32'd0);
    check("rst_readdata", {24'b0, READDATA}, 32'd0);
    check("rst_mem_read", {31'b0, mem_read}, 32'd0);
    check("rst_mem_write", {31'b0, mem_write}, 32'd0);
    check("rst_mem_addr", {26'b0, mem_address}, 32'd0);
    check("rst_mem_wdata", mem_writedata, 32'd0);
    @(negedge CLK);
    RESET = 0;

    access(0, 8'h25, 8'h00, 3);
    check("cold_busy", obs_busy, 5);
    check("cold_fill_addr", {26'b0, obs_rd_addr}, 32'h09);
    check("cold_rdata", {24'b0, obs_rdata}, 32'hBB);
    access(0, 8'h27, 8'h00, 3);
    check("hit_rdata", {24'b0, obs_rdata}, 32'hDD);
    check("hit_no_fill", {31'b0, obs_saw_rd}, 32'd0);
    access(1, 8'h24, 8'h5A, 2);
    check("wrhit_busy", obs_busy, 0);
    access(0, 8'h45, 8'h00, 2);
    check("evict_addr", {26'b0, obs_wb_addr}, 32'h09);
    check("evict_data", obs_wb_data, 32'hDDCCBB5A);
    check("evict_fill_addr", {26'b0, obs_rd_addr}, 32'h11);
    access(1, 8'h81, 8'h33, 2);
    check("wrmiss_no_wb", {31'b0, obs_saw_wr}, 32'd0);
    access(0, 8'h81, 8'h00, 2);
    check("wrmiss_rdata", {24'b0, obs_rdata}, 32'h33);
    access(0, 8'hA1, 8'h00, 2);
    check("wrmiss_dirty_wb", {31'b0, obs_saw_wr}, 32'd1);
    access(0, 8'h0C, 8'h00, 11);
    check("stretch_busy", obs_busy, 13);

    for (int t = 0; t < 60; t++) begin
      logic [2:0] rtg, ridx;
      logic [1:0] roff;
      rtg  = 3'($urandom_range(0, 3));
      ridx = 3'($urandom_range(0, 7));
      roff = 2'($urandom_range(0, 3));
      access(1'($urandom_range(0, 1)), {rtg, ridx, roff}, 8'($urandom), $urandom_range(1, 4));
    end

    begin
      int i;
      mem_lat = 20;
      @(negedge CLK);
      READ = 1; ADDRESS = {m_tag[1] + 3'd1, 3'd1, 2'd1};
      i = 0;
      #1;
      while (!mem_read && i < 100) begin @(negedge CLK); #1; i++; end
      check("rstfill_reached", {31'b0, mem_read}, 32'd1);
      repeat (2) @(negedge CLK);
      RESET = 1; READ = 0;
      @(posedge CLK); #1;
      check("rstfill_mem_read", {31'b0, mem_read}, 32'd0);
      check("rstfill_mem_write", {31'b0, mem_write}, 32'd0);
      check("rstfill_busywait", {31'b0, BUSYWAIT}, 32'd0);
      @(negedge CLK);
      RESET = 0;
      model_reset();
    end
    access(0, 8'h25, 8'h00, 3);
    check("after_rst_miss", obs_busy, 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
